// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction prefetcher with a credit-checked prefetch buffer.
//
// Issues sequential word fetches to an in-order instruction memory. Every request
// reserves a slot in the prefetch buffer before it is issued, so a kept response can
// always be written without stalling the memory side. A redirect flushes the buffer,
// jumps the fetch PC and marks every response still in flight as stale.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   fetch_en_i            allow new memory requests
//   redirect_valid_i      flush and jump to redirect_pc_i (usable in the same cycle)
//   redirect_pc_i         jump target
//   instmem_valid_o       request valid, held until instmem_ready_i
//   instmem_ready_i       memory accepts the request
//   instmem_addr_o        request address
//   instmem_rvalid_i      response valid (responses return in request order)
//   instmem_rdata_i       response data
//   inst_valid_o          prefetch buffer head valid
//   inst_ready_i          consumer takes the head entry
//   inst_pc_o, inst_data_o  head entry PC and instruction word
//   outstanding_o         number of requests awaiting a response
//   drop_pending_o        stale responses are still expected
//
// DepthLog2 must be at least 1.
module fetch_unit #(
    parameter int unsigned     Xlen           = 32,
    parameter int unsigned     Ilen           = 32,
    parameter int unsigned     DepthLog2      = 2,
    parameter int unsigned     MaxOutstanding = 2,
    parameter logic [Xlen-1:0] ResetPc        = '0
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  fetch_en_i,
    input  logic                                  redirect_valid_i,
    input  logic [Xlen-1:0]                       redirect_pc_i,
    input  logic                                  instmem_ready_i,
    output logic                                  instmem_valid_o,
    output logic [Xlen-1:0]                       instmem_addr_o,
    input  logic [Ilen-1:0]                       instmem_rdata_i,
    input  logic                                  instmem_rvalid_i,
    output logic                                  inst_valid_o,
    input  logic                                  inst_ready_i,
    output logic [Xlen-1:0]                       inst_pc_o,
    output logic [Ilen-1:0]                       inst_data_o,
    output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o,
    output logic                                  drop_pending_o
);

    localparam int unsigned Depth = 2 ** DepthLog2;
    localparam int unsigned PtrW  = DepthLog2;
    localparam int unsigned CntW  = DepthLog2 + 1;
    localparam int unsigned OutW  = $clog2(MaxOutstanding + 1);
    localparam int unsigned TagW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    // Fetch PC and request bookkeeping
    logic [Xlen-1:0] pc_q, pc_d;
    logic [OutW-1:0] out_q, out_d;
    logic [OutW-1:0] drop_q, drop_d;

    // Tag queue: PC of each request still awaiting its response, oldest at tag_rd_q
    logic [Xlen-1:0] tag_q [MaxOutstanding];
    logic [TagW-1:0] tag_wr_q, tag_wr_d;
    logic [TagW-1:0] tag_rd_q, tag_rd_d;

    // Prefetch buffer
    logic [Xlen-1:0] buf_pc_q   [Depth];
    logic [Ilen-1:0] buf_data_q [Depth];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic            out_ok;
    logic            credit_ok;
    logic            req_valid;
    logic            req_fire;
    logic [Xlen-1:0] req_addr;
    logic            rsp_fire;
    logic            buf_push;
    logic            buf_pop;

    function automatic logic [TagW-1:0] tag_next(input logic [TagW-1:0] p);
        if (p == TagW'(MaxOutstanding - 1)) begin
            return '0;
        end
        return p + TagW'(1);
    endfunction

    // A request is only issued if its response is guaranteed a buffer slot.
    assign out_ok    = 32'(out_q) < 32'(MaxOutstanding);
    assign credit_ok = (32'(out_q) + 32'(cnt_q)) < 32'(Depth);
    assign req_valid = !rst_i && fetch_en_i && out_ok && credit_ok;
    assign req_addr  = redirect_valid_i ? redirect_pc_i : pc_q;
    assign req_fire  = req_valid && instmem_ready_i;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_fire  = instmem_rvalid_i && (out_q != '0);
    // Responses in a redirect cycle or while stale ones remain are discarded.
    assign buf_push  = rsp_fire && !redirect_valid_i && (drop_q == '0);
    assign buf_pop   = inst_valid_o && inst_ready_i;

    always_comb begin
        pc_d     = pc_q;
        out_d    = out_q;
        drop_d   = drop_q;
        tag_wr_d = tag_wr_q;
        tag_rd_d = tag_rd_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;

        if (req_fire) begin
            pc_d     = req_addr + Xlen'(4);
            tag_wr_d = tag_next(tag_wr_q);
        end else if (redirect_valid_i) begin
            pc_d = redirect_pc_i;
        end

        // Dropped responses still retire their tag to keep the queue aligned.
        if (rsp_fire) begin
            tag_rd_d = tag_next(tag_rd_q);
        end

        case ({req_fire, rsp_fire})
            2'b10:   out_d = out_q + OutW'(1);
            2'b01:   out_d = out_q - OutW'(1);
            default: out_d = out_q;
        endcase

        if (redirect_valid_i) begin
            // Every request outstanding before this cycle is stale; the one answered
            // in this cycle is already being discarded. A request accepted now is new.
            drop_d   = out_q - OutW'(rsp_fire);
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (rsp_fire && (drop_q != '0)) begin
                drop_d = drop_q - OutW'(1);
            end
            if (buf_push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (buf_pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            case ({buf_push, buf_pop})
                2'b10:   cnt_d = cnt_q + CntW'(1);
                2'b01:   cnt_d = cnt_q - CntW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q     <= ResetPc;
            out_q    <= '0;
            drop_q   <= '0;
            tag_wr_q <= '0;
            tag_rd_q <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            pc_q     <= pc_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
            tag_wr_q <= tag_wr_d;
            tag_rd_q <= tag_rd_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage arrays need no reset; validity is tracked by the pointers and counts.
    always_ff @(posedge clk_i) begin
        if (req_fire) begin
            tag_q[tag_wr_q] <= req_addr;
        end
        if (buf_push) begin
            buf_pc_q[wr_ptr_q]   <= tag_q[tag_rd_q];
            buf_data_q[wr_ptr_q] <= instmem_rdata_i;
        end
    end

    assign instmem_valid_o = req_valid;
    assign instmem_addr_o  = req_addr;
    assign inst_valid_o    = (cnt_q != '0);
    assign inst_pc_o       = buf_pc_q[rd_ptr_q];
    assign inst_data_o     = buf_data_q[rd_ptr_q];
    assign outstanding_o   = out_q;
    assign drop_pending_o  = (drop_q != '0);

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter Xlen, default 32, address/PC width.
REQ-002 SHALL have parameter Ilen, default 32, instruction width.
REQ-003 SHALL have parameter DepthLog2, default 2, prefetch buffer holds 2**DepthLog2 entries.
REQ-004 SHALL have parameter MaxOutstanding, default 2, maximum unanswered memory requests, range 1..2**DepthLog2.
REQ-005 SHALL have parameter ResetPc, default 0, first fetch address.
REQ-006 SHALL have ports: clk_i in 1 clock; rst_i in 1 reset, one clock, asynchronous, active-high.
REQ-007 SHALL have ports: fetch_en_i in 1 allow new requests; redirect_valid_i in 1 flush and jump; redirect_pc_i in Xlen jump target.
REQ-008 SHALL have ports: instmem_ready_i in 1; instmem_valid_o out 1; instmem_addr_o out Xlen; instmem_rdata_i in Ilen; instmem_rvalid_i in 1. Responses return in request order.
REQ-009 SHALL have ports: inst_valid_o out 1; inst_ready_i in 1; inst_pc_o out Xlen; inst_data_o out Ilen.
REQ-010 SHALL have ports: outstanding_o out $clog2(MaxOutstanding+1) live request count; drop_pending_o out 1, stale responses still expected.

Function
REQ-011 SHALL use a request PC register pc_q; an accepted request (instmem_valid_o && instmem_ready_i) advances pc_q to the issued address + 4, modulo 2**Xlen.
REQ-012 SHALL assert instmem_valid_o only when fetch_en_i=1, outstanding < MaxOutstanding, and outstanding + buffer occupancy < 2**DepthLog2 (credit rule: every response has a slot).
REQ-013 SHALL drive instmem_addr_o = redirect_pc_i when redirect_valid_i=1, else pc_q (same-cycle bypass); instmem_valid_o SHALL be stable while not accepted unless redirect occurs.
REQ-014 SHALL tag each accepted request's PC in an in-order tag queue of depth MaxOutstanding; each kept response pushes {tag PC, rdata} into the buffer.
REQ-015 SHALL present buffer head on inst_*; pop on inst_valid_o && inst_ready_i; push and pop in the same cycle when full SHALL both occur.
REQ-016 SHALL, on redirect_valid_i: empty the buffer, deassert inst_valid_o next cycle, set drop count = outstanding requests before this cycle minus 1 if instmem_rvalid_i this cycle, else outstanding; the response arriving in the redirect cycle SHALL be discarded.
REQ-017 SHALL, while drop count > 0, discard each response and decrement; drop_pending_o = (drop count != 0).
REQ-018 SHALL keep a request accepted in the redirect cycle (address redirect_pc_i) and its response, outside the drop count.
REQ-019 SHALL, on redirect with drop count already nonzero, add the newly stale requests to the existing count.
REQ-020 SHALL count outstanding as +1 per accepted request, -1 per response (kept or dropped), both in one cycle = unchanged.
REQ-021 SHALL, with fetch_en_i=0, issue nothing new but still accept responses and serve the buffer.
REQ-022 SHALL treat a response with outstanding=0 as a protocol error: ignored, no state change.
REQ-023 SHALL add zero cycles from instmem_rvalid_i to buffer write; data SHALL be visible on inst_*_o the cycle after a push into an empty buffer.

Reset
REQ-024 SHALL on rst_i immediately set: pc_q=ResetPc, buffer empty, outstanding=0, drop count=0, instmem_valid_o=0, inst_valid_o=0, drop_pending_o=0.
REQ-025 SHALL discard responses from requests issued before reset; memory SHALL be reset alongside.
REQ-026 SHALL issue the first request at ResetPc the first cycle after rst_i deasserts with fetch_en_i=1.

Verification
REQ-027 Streaming: ready always 1, rvalid 1 cycle after accept, inst_ready_i=1 -> PCs 0x0,0x4,0x8,0xC delivered in order, one per cycle steady state.
REQ-028 Backpressure: inst_ready_i=0, defaults -> exactly 4 entries buffered, instmem_valid_o=0 with outstanding=0; release -> 0x0..0xC then refetch at 0x10.
REQ-029 Redirect with 2 in flight to 0x100 -> drop_pending_o=1, next 2 responses discarded, first delivered PC 0x100.
REQ-030 Redirect coincident with a response and an accepted request -> coincident response dropped, request at redirect_pc_i kept and delivered.
REQ-031 Back-to-back redirects to 0x200 then 0x300 with responses delayed 3 cycles -> only 0x300 stream delivered; outstanding returns to 0.
REQ-032 Reset asserted mid-stream asynchronously -> all outputs at reset values same cycle; first request after release at ResetPc.
